instruction_register: RTL and testbench
=======================================

# instruction_register

Instruction register (IR) for the 16-bit CPU datapath. Captures the instruction word from the memory data bus on a clock edge when enabled, holds it stably for the control unit, and exposes fixed instruction fields for decode. It sits between the instruction-fetch path and the control/decode logic.

## Interface
Parameters:
- `RESET_VALUE`, default `16'h0000`: value loaded into the register on reset.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset; the port keeps the codebase name `rst`, and driving it low resets the block.
- `en`  input  1  load enable; high = capture `d` on the next rising edge.
- `d`  input  16  instruction word to load.
- `o`  output  16  registered instruction word.
- `opcode`  output  4  `o[15:12]`.
- `rd`  output  4  `o[11:8]`.
- `rs1`  output  4  `o[7:4]`.
- `rs2`  output  4  `o[3:0]`.
- `imm8`  output  8  `o[7:0]`.
- `loaded`  output  1  high once at least one load has completed since the last reset.

## Operation
- One 16-bit register drives `o`, plus one flag register drives `loaded`.
- `rst` low: register = `RESET_VALUE` and `loaded` = 0, immediately, independent of `clk`. Both stay there while `rst` is low, regardless of `en`.
- `rst` high, rising edge, `en` = 1: register <= `d`, and `loaded` <= 1.
- `rst` high, rising edge, `en` = 0: register and `loaded` hold their values.
- Field outputs are purely combinational slices of the registered `o`, never of `d`.
- Fields overlap by design: `imm8` aliases `{rs1, rs2}`. Interpretation belongs to the control unit.
- No arithmetic, no saturation. Every 16-bit value is stored verbatim.

## Timing
- Load latency: `o` shows the new `d` right after the rising edge on which `en` = 1 is sampled. This is 1 cycle.
- Field outputs and `loaded` carry no extra latency beyond `o`.
- `d` and `en` must meet setup/hold to `clk`. `en` is level-sensitive and is sampled on every edge.
- Back-to-back loads, with `en` held high, capture a new word every cycle.
- Reset assertion is asynchronous: `o` goes to `RESET_VALUE` within the same cycle, without waiting for a clock edge.
- Reset deassertion: the first load can occur on the first rising edge after `rst` goes high.
- Reset asserted while `en` is high wins. No load occurs.
- Reset in mid-operation discards the held instruction.

## Configuration
- `IR_DECODE_EN`: when defined, `opcode`, `rd`, `rs1`, `rs2` and `imm8` are driven from `o` as specified.
- When not defined, those ports still exist but are tied to 0. Only `o` and `loaded` are functional. This lets the control unit decode from `o` directly.

## Test plan
- Power-up reset: `rst` = 0 with `d` = `16'hFFFF` and `en` = 1 -> `o` = `16'h0000`, `loaded` = 0 immediately, and both hold across edges.
- Load: `rst` = 1, `en` = 1, `d` = `16'h00FF` -> after 1 rising edge `o` = `16'h00FF`, `loaded` = 1.
- Hold: `en` = 0, `d` = `16'h1234` for 3 cycles -> `o` stays `16'h00FF`.
- Async reset mid-cycle: with `o` = `16'h00FF`, drop `rst` between edges -> `o` = `16'h0000`, `loaded` = 0 before the next edge. Then `en` = 0 and `d` = 0 after release -> `o` remains `16'h0000`.
- Back-to-back and decode (with `IR_DECODE_EN`): load `16'hA5C3` and then `16'h3E01` on consecutive edges.
  - After the first load: `opcode` = `4'hA`, `rd` = `4'h5`, `rs1` = `4'hC`, `rs2` = `4'h3`, `imm8` = `8'hC3`.
  - After the second load: `opcode` = `4'h3`, `imm8` = `8'h01`.
- Decode disabled (without `IR_DECODE_EN`): load `16'hA5C3` -> `o` = `16'hA5C3`, and all field outputs = 0.

Source files
------------

// File: rtl/instruction_register.sv
// instruction_register: 16-bit instruction register for the CPU datapath.
// Captures the memory data bus word when enabled, holds it for the control
// unit, and reports whether any word has been captured since reset.
// Optional feature macro: IR_DECODE_EN. When it is defined, the opcode/rd/
// rs1/rs2/imm8 field outputs are slices of the held word. When it is left
// undefined, those ports remain present but are tied to zero.
// Port names follow the existing datapath codebase. rst is active-low and
// asynchronous.

module instruction_register #(
    parameter logic [15:0] RESET_VALUE = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] d,
    output logic [15:0] o,
    output logic [3:0]  opcode,
    output logic [3:0]  rd,
    output logic [3:0]  rs1,
    output logic [3:0]  rs2,
    output logic [7:0]  imm8,
    output logic        loaded
);

    logic [15:0] r_ir;
    logic        r_loaded;

    // Capture the instruction word and set the loaded flag; reset wins over enable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ir     <= RESET_VALUE;
            r_loaded <= 1'b0;
        end else if (en) begin
            r_ir     <= d;
            r_loaded <= 1'b1;
        end else begin
            r_ir     <= r_ir;
            r_loaded <= r_loaded;
        end
    end

    assign o      = r_ir;
    assign loaded = r_loaded;

`ifdef IR_DECODE_EN
    // Field slices come from the held word, never from d; imm8 overlaps rs1/rs2
    always_comb begin
        opcode = r_ir[15:12];
        rd     = r_ir[11:8];
        rs1    = r_ir[7:4];
        rs2    = r_ir[3:0];
        imm8   = r_ir[7:0];
    end
`else
    // Decode is left to the control unit, so the field ports are held at zero
    always_comb begin
        opcode = 4'h0;
        rd     = 4'h0;
        rs1    = 4'h0;
        rs2    = 4'h0;
        imm8   = 8'h00;
    end
`endif

endmodule

// File: tb/tb_instruction_register.sv
// Bench for instruction_register. The driver updates a behavioural model and
// queues the expected response. Independent monitors then pop and compare the
// queued values, either after each rising edge or right after an asynchronous
// reset drop.

module tb_instruction_register;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [15:0] d   = 16'h0000;
    logic [15:0] o;
    logic [3:0]  opcode, rd, rs1, rs2;
    logic [7:0]  imm8;
    logic        loaded;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [15:0] word;
        logic        ld;
    } exp_t;

    exp_t clk_q[$];
    exp_t async_q[$];
    event async_ev;
    bit   done = 1'b0;

    // Model state: what the register should hold
    logic [15:0] m_word   = 16'h0000;
    logic        m_loaded = 1'b0;

    instruction_register #(.RESET_VALUE(16'h0000)) dut (
        .clk(clk), .rst(rst), .en(en), .d(d), .o(o),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .imm8(imm8),
        .loaded(loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // Expected field value: a bit range of the word if decode is built in, else zero
    function automatic logic [15:0] field(input logic [15:0] w, input int lsb, input int bits);
`ifdef IR_DECODE_EN
        return (w / (16'd1 << lsb)) % (16'd1 << bits);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic compare(input exp_t e);
        chk({e.name, ".o"},      o,               e.word);
        chk({e.name, ".loaded"}, {15'd0, loaded}, {15'd0, e.ld});
        chk({e.name, ".opcode"}, {12'd0, opcode}, field(e.word, 12, 4));
        chk({e.name, ".rd"},     {12'd0, rd},     field(e.word, 8, 4));
        chk({e.name, ".rs1"},    {12'd0, rs1},    field(e.word, 4, 4));
        chk({e.name, ".rs2"},    {12'd0, rs2},    field(e.word, 0, 4));
        chk({e.name, ".imm8"},   {8'd0, imm8},    field(e.word, 0, 8));
    endtask

    // Clocked monitor: checks the state right after every rising edge that has an expectation
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (clk_q.size() > 0) compare(clk_q.pop_front());
        end
    end

    // Async monitor: checks the state shortly after reset is dropped, before any edge
    initial begin
        forever begin
            @(async_ev);
            #1;
            while (async_q.size() > 0) compare(async_q.pop_front());
        end
    end

    // One clock cycle of stimulus, applied at the falling edge
    task automatic cycle(input logic rv, input logic ev, input logic [15:0] dv, input string nm);
        exp_t e;
        @(negedge clk);
        rst = rv;
        en  = ev;
        d   = dv;
        if (!rv) begin
            m_word   = 16'h0000;
            m_loaded = 1'b0;
        end else if (ev) begin
            m_word   = dv;
            m_loaded = 1'b1;
        end
        e.name = nm;
        e.word = m_word;
        e.ld   = m_loaded;
        clk_q.push_back(e);
    endtask

    // Drop reset between edges and expect the cleared state straight away
    task automatic async_drop(input string nm);
        exp_t e;
        @(negedge clk);
        #2;
        rst      = 1'b0;
        m_word   = 16'h0000;
        m_loaded = 1'b0;
        e.name   = nm;
        e.word   = m_word;
        e.ld     = m_loaded;
        async_q.push_back(e);
        ->async_ev;
        #2;
    endtask

    // Watchdog so the run always ends
    initial begin
        #200000;
        if (!done) begin
            $display("FAIL watchdog: run did not finish, got timeout, expected completion");
            errors++;
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $fatal(1, "timeout");
        end
    end

    // Stimulus: directed plan then randomized traffic
    initial begin
        exp_t e;
        // Power-up: reset asserted with en=1 and d all ones
        #1;
        d   = 16'hFFFF;
        en  = 1'b1;
        rst = 1'b0;
        e.name = "por_async"; e.word = 16'h0000; e.ld = 1'b0;
        async_q.push_back(e);
        ->async_ev;
        #2;
        cycle(1'b0, 1'b1, 16'hFFFF, "por_hold0");
        cycle(1'b0, 1'b1, 16'hFFFF, "por_hold1");
        // Load
        cycle(1'b1, 1'b1, 16'h00FF, "load");
        // Hold for three cycles
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'h1234, "hold");
        // Async reset between edges, then release with en low
        async_drop("mid_reset");
        cycle(1'b1, 1'b0, 16'h0000, "post_release0");
        cycle(1'b1, 1'b0, 16'h0000, "post_release1");
        // Back-to-back loads with decode
        cycle(1'b1, 1'b1, 16'hA5C3, "b2b_first");
        cycle(1'b1, 1'b1, 16'h3E01, "b2b_second");
        cycle(1'b1, 1'b0, 16'hFFFF, "b2b_hold");
        // Reset asserted while en is high: no load
        cycle(1'b0, 1'b1, 16'h5555, "rst_vs_en");
        cycle(1'b1, 1'b1, 16'hA5C3, "reload");
        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic        rv;
            logic        ev;
            logic [15:0] dv;
            rv = ($urandom_range(0, 15) != 0);
            ev = $urandom_range(0, 1);
            dv = 16'($urandom);
            if ($urandom_range(0, 31) == 0) async_drop("rand_async");
            cycle(rv, ev, dv, "rand");
        end
        cycle(1'b1, 1'b0, 16'h0000, "tail");
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        if (clk_q.size() != 0 || async_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, expected 0", clk_q.size() + async_q.size());
        end
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
